// File: rtl/turf_cmd_pkg.sv
// ---------------------------------------------------------------------------
// turf_cmd_pkg
// Shared definitions for the TURF->SURF command serializer: frame geometry
// constants, the idle line level, the serializer state enum, and the parity
// helper used when a command word is latched.
// ---------------------------------------------------------------------------
package turf_cmd_pkg;

  localparam int   CMD_DATA_BITS  = 32;
  // Start bit + 32 data bits + parity bit.
  localparam int   CMD_FRAME_BITS = 34;
  localparam logic CMD_IDLE_LEVEL = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_GAP    = 3'd4
  } cmd_state_e;

  // Odd parity: the returned bit makes the total number of ones
  // (data + parity) odd.
  function automatic logic odd_parity(input logic [CMD_DATA_BITS-1:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/turf_cmd_bit_timer.sv
// ---------------------------------------------------------------------------
// turf_cmd_bit_timer
// Divides the clock into serial bit-times of BIT_CYCLES cycles. While enabled
// it counts 0..BIT_CYCLES-1 and raises bit_end_o during the last cycle of
// each bit-time. load_i restarts the count at 0.
//
// Ports:
//   clk_i      in   clock
//   reset_i    in   synchronous active-high reset
//   en_i       in   count enable (a frame or gap is in progress)
//   load_i     in   restart the bit-time at count 0
//   bit_end_o  out  high in the final cycle of the current bit-time
// ---------------------------------------------------------------------------
module turf_cmd_bit_timer #(
  parameter int BIT_CYCLES = 1
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic en_i,
  input  logic load_i,
  output logic bit_end_o
);

  // At least one bit of counter even when BIT_CYCLES=1; the counter then
  // never leaves 0 because every enabled cycle is a bit end.
  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign bit_end_o = en_i & (cnt_q == CW'(BIT_CYCLES - 1));

  // Next count: wrap on bit end or restart on load, otherwise advance while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i || bit_end_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/turf_cmd_serializer.sv
// ---------------------------------------------------------------------------
// turf_cmd_serializer
// Frames 32-bit TURF->SURF command words as: start bit (1), data MSB first,
// odd-parity bit, then GAP_BITS idle bit-times. The frame is broadcast on
// every CMD line selected by the mask latched with the word; unselected lines
// stay at the idle level. Upstream hands words over with valid/ready.
//
// Ports:
//   CLK125         in   clock, all logic on its rising edge
//   reset_i        in   synchronous active-high reset
//   cmd_data_i     in   [31:0] command word
//   cmd_mask_i     in   [NUM_SURFS-1:0] 1 = SURF receives this frame
//   cmd_valid_i    in   upstream offers a word
//   cmd_ready_o    out  word can be accepted (IDLE only)
//   CMD            out  [NUM_SURFS-1:0] serial command lines, idle low
//   busy_o         out  frame or gap in progress
//   frame_count_o  out  [15:0] completed frames, wraps
// ---------------------------------------------------------------------------
module turf_cmd_serializer
  import turf_cmd_pkg::*;
#(
  parameter int NUM_SURFS  = 12,
  parameter int BIT_CYCLES = 1,
  parameter int GAP_BITS   = 2
) (
  input  logic                 CLK125,
  input  logic                 reset_i,
  input  logic [31:0]          cmd_data_i,
  input  logic [NUM_SURFS-1:0] cmd_mask_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  output logic [NUM_SURFS-1:0] CMD,
  output logic                 busy_o,
  output logic [15:0]          frame_count_o
);

  cmd_state_e               state_q;
  logic [CMD_DATA_BITS-1:0] data_q;
  logic [NUM_SURFS-1:0]     mask_q;
  logic                     parity_q;
  logic [4:0]               idx_q;
  logic [3:0]               gap_q;
  logic [NUM_SURFS-1:0]     cmd_q;
  logic                     ready_q;
  logic                     busy_q;
  logic [15:0]              count_q;

  logic accept_s;
  logic bit_end_s;
  logic timer_en_s;

  assign accept_s   = (state_q == ST_IDLE) & ready_q & cmd_valid_i;
  assign timer_en_s = (state_q != ST_IDLE);

  turf_cmd_bit_timer #(
    .BIT_CYCLES (BIT_CYCLES)
  ) u_bit_timer (
    .clk_i     (CLK125),
    .reset_i   (reset_i),
    .en_i      (timer_en_s),
    .load_i    (accept_s),
    .bit_end_o (bit_end_s)
  );

  // Serializer FSM. CMD is loaded with the value of the upcoming bit at the
  // edge that enters each bit-time, so the wire is fully registered.
  always_ff @(posedge CLK125) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      data_q   <= '0;
      mask_q   <= '0;
      parity_q <= 1'b0;
      idx_q    <= 5'd0;
      gap_q    <= 4'd0;
      cmd_q    <= {NUM_SURFS{CMD_IDLE_LEVEL}};
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      count_q  <= 16'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ready_q <= 1'b1;
          cmd_q   <= {NUM_SURFS{CMD_IDLE_LEVEL}};
          if (accept_s) begin
            data_q   <= cmd_data_i;
            mask_q   <= cmd_mask_i;
            parity_q <= odd_parity(cmd_data_i);
            // Start bit is a 1 on every selected line.
            cmd_q    <= cmd_mask_i;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= ST_START;
          end
        end

        ST_START: begin
          if (bit_end_s) begin
            idx_q   <= 5'd31;
            cmd_q   <= mask_q & {NUM_SURFS{data_q[31]}};
            state_q <= ST_DATA;
          end
        end

        ST_DATA: begin
          if (bit_end_s) begin
            if (idx_q == 5'd0) begin
              cmd_q   <= mask_q & {NUM_SURFS{parity_q}};
              state_q <= ST_PARITY;
            end else begin
              idx_q <= idx_q - 5'd1;
              cmd_q <= mask_q & {NUM_SURFS{data_q[idx_q - 5'd1]}};
            end
          end
        end

        ST_PARITY: begin
          if (bit_end_s) begin
            cmd_q   <= {NUM_SURFS{CMD_IDLE_LEVEL}};
            gap_q   <= 4'd0;
            count_q <= count_q + 16'd1;
            state_q <= ST_GAP;
          end
        end

        ST_GAP: begin
          if (bit_end_s) begin
            if (gap_q == 4'(GAP_BITS - 1)) begin
              busy_q  <= 1'b0;
              ready_q <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              gap_q <= gap_q + 4'd1;
            end
          end
        end

        default: begin
          cmd_q   <= {NUM_SURFS{CMD_IDLE_LEVEL}};
          busy_q  <= 1'b0;
          ready_q <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign CMD           = cmd_q;
  assign cmd_ready_o   = ready_q;
  assign busy_o        = busy_q;
  assign frame_count_o = count_q;

endmodule

// File: tb/tb_turf_cmd_serializer.sv
// ---------------------------------------------------------------------------
// tb_turf_cmd_serializer
// Two serializer instances: default timing (BIT_CYCLES=1) and a slow one
// (BIT_CYCLES=4). Expected wire values come from the frame rules: bit-time
// b of a frame is start(1), data[31..0], odd parity; CMD = bit ? mask : 0.
// ---------------------------------------------------------------------------
module tb_turf_cmd_serializer;

  localparam int NS  = 12;
  localparam int GAP = 2;

  logic          clk = 1'b0;
  logic          rst1, rst4;
  logic [31:0]   cmd_data;
  logic [NS-1:0] cmd_mask;
  logic          valid1, valid4;
  logic          ready1, ready4;
  logic [NS-1:0] cmd1, cmd4;
  logic          busy1, busy4;
  logic [15:0]   fc1, fc4;

  int checks = 0;
  int errors = 0;
  int fc_model1 = 0;
  int fc_model4 = 0;

  always #4 clk = ~clk;

  turf_cmd_serializer #(.NUM_SURFS(NS), .BIT_CYCLES(1), .GAP_BITS(GAP)) dut1 (
    .CLK125(clk), .reset_i(rst1), .cmd_data_i(cmd_data), .cmd_mask_i(cmd_mask),
    .cmd_valid_i(valid1), .cmd_ready_o(ready1), .CMD(cmd1), .busy_o(busy1),
    .frame_count_o(fc1));

  turf_cmd_serializer #(.NUM_SURFS(NS), .BIT_CYCLES(4), .GAP_BITS(GAP)) dut4 (
    .CLK125(clk), .reset_i(rst4), .cmd_data_i(cmd_data), .cmd_mask_i(cmd_mask),
    .cmd_valid_i(valid4), .cmd_ready_o(ready4), .CMD(cmd4), .busy_o(busy4),
    .frame_count_o(fc4));

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [NS-1:0] o_cmd(int s);
    return (s == 0) ? cmd1 : cmd4;
  endfunction
  function automatic logic o_ready(int s);
    return (s == 0) ? ready1 : ready4;
  endfunction
  function automatic logic o_busy(int s);
    return (s == 0) ? busy1 : busy4;
  endfunction
  function automatic logic [15:0] o_fc(int s);
    return (s == 0) ? fc1 : fc4;
  endfunction

  // Expected CMD in cycle c (1-based after the accept edge).
  function automatic logic [NS-1:0] exp_cmd(logic [31:0] d, logic [NS-1:0] m, int bc, int c);
    int   b;
    logic bitv;
    if (c < 1 || c > 34 * bc) return '0;
    b = (c - 1) / bc;
    if (b == 0)       bitv = 1'b1;
    else if (b <= 32) bitv = d[32 - b];
    else              bitv = (($countones(d) % 2) == 0);
    return bitv ? m : '0;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_valid(int s, logic v);
    if (s == 0) valid1 = v;
    else        valid4 = v;
  endtask

  // Wait (bounded) for ready, present a word and let the accept edge happen.
  task automatic send(int s, logic [31:0] d, logic [NS-1:0] m, bit hold);
    bit got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (o_ready(s) === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    check("ready_wait", 32'(got), 32'd1);
    cmd_data = d;
    cmd_mask = m;
    set_valid(s, 1'b1);
    @(posedge clk);
    #1;
    if (!hold) set_valid(s, 1'b0);
  endtask

  // Check a whole frame + gap, starting right after its accept edge. At
  // cycle 5 the inputs are changed to (nd, nm) to show they are ignored.
  task automatic check_frame(int s, logic [31:0] d, logic [NS-1:0] m,
                             logic [31:0] nd, logic [NS-1:0] nm);
    int bc    = (s == 0) ? 1 : 4;
    int total = (34 + GAP) * bc;
    int fc    = (s == 0) ? fc_model1 : fc_model4;
    for (int c = 1; c <= total; c++) begin
      @(negedge clk);
      check("cmd", 32'(o_cmd(s)), 32'(exp_cmd(d, m, bc, c)));
      check("busy", 32'(o_busy(s)), 32'd1);
      check("ready_low", 32'(o_ready(s)), 32'd0);
      check("fcount_mid", 32'(o_fc(s)), 32'((c <= 34 * bc) ? fc : fc + 1) & 32'hFFFF);
      if (c == 5) begin
        cmd_data = nd;
        cmd_mask = nm;
      end
    end
    fc = (fc + 1) & 16'hFFFF;
    if (s == 0) fc_model1 = fc;
    else        fc_model4 = fc;
    @(negedge clk);
    check("ready_ret", 32'(o_ready(s)), 32'd1);
    check("busy_end", 32'(o_busy(s)), 32'd0);
    check("cmd_idle", 32'(o_cmd(s)), 32'd0);
    check("fcount", 32'(o_fc(s)), 32'(fc));
  endtask

  logic [31:0]   rd;
  logic [NS-1:0] rm;

  initial begin
    rst1 = 1'b1; rst4 = 1'b1;
    valid1 = 1'b0; valid4 = 1'b0;
    cmd_data = 32'h0; cmd_mask = '0;

    // Reset state
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check("rst_cmd", 32'(o_cmd(s)), 32'd0);
      check("rst_ready", 32'(o_ready(s)), 32'd0);
      check("rst_busy", 32'(o_busy(s)), 32'd0);
      check("rst_fc", 32'(o_fc(s)), 32'd0);
    end
    rst1 = 1'b0; rst4 = 1'b0;
    @(negedge clk);
    check("ready_after_rst1", 32'(ready1), 32'd1);
    check("ready_after_rst4", 32'(ready4), 32'd1);

    // Reference frame, all lines
    send(0, 32'hA5A5_0001, 12'hFFF, 1'b0);
    check_frame(0, 32'hA5A5_0001, 12'hFFF, 32'hFFFF_FFFF, 12'h000);

    // Lines 0 and 2 only, zero data -> parity 1
    send(0, 32'h0000_0000, 12'h005, 1'b0);
    check_frame(0, 32'h0000_0000, 12'h005, 32'h1234_5678, 12'hFFF);

    // Empty mask still runs full timing and is counted
    send(0, 32'hDEAD_BEEF, 12'h000, 1'b0);
    check_frame(0, 32'hDEAD_BEEF, 12'h000, 32'h0, 12'hFFF);

    // Random words and masks
    for (int i = 0; i < 4; i++) begin
      rd = $urandom;
      rm = 12'($urandom_range(0, 4095));
      send(0, rd, rm, 1'b0);
      check_frame(0, rd, rm, $urandom, 12'($urandom));
    end

    // Back-to-back: valid held high, second word waits and is taken at cycle 37
    send(0, 32'hCAFE_0123, 12'hA5A, 1'b1);
    check_frame(0, 32'hCAFE_0123, 12'hA5A, 32'h0F0F_F0F0, 12'h3C3);
    @(posedge clk);
    #1;
    valid1 = 1'b0;
    check_frame(0, 32'h0F0F_F0F0, 12'h3C3, 32'h5555_AAAA, 12'hFFF);

    // Slow instance: 4 cycles per bit, ready at cycle 145
    send(1, 32'h8000_0000, 12'hFFF, 1'b0);
    check_frame(1, 32'h8000_0000, 12'hFFF, 32'h7FFF_FFFF, 12'h001);
    rd = $urandom;
    rm = 12'($urandom);
    send(1, rd, rm, 1'b0);
    check_frame(1, rd, rm, ~rd, ~rm);

    // Reset pulsed at cycle 10 of a frame (valid also high): frame discarded
    send(0, 32'hFFFF_FFFF, 12'hFFF, 1'b0);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      check("pre_rst_cmd", 32'(cmd1), 32'(exp_cmd(32'hFFFF_FFFF, 12'hFFF, 1, c)));
    end
    rst1 = 1'b1;
    valid1 = 1'b1;
    @(negedge clk);
    fc_model1 = 0;
    check("midrst_cmd", 32'(cmd1), 32'd0);
    check("midrst_ready", 32'(ready1), 32'd0);
    check("midrst_busy", 32'(busy1), 32'd0);
    check("midrst_fc", 32'(fc1), 32'd0);
    rst1 = 1'b0;
    valid1 = 1'b0;
    @(negedge clk);
    check("postrst_ready", 32'(ready1), 32'd1);
    check("postrst_cmd", 32'(cmd1), 32'd0);

    // Reset and valid together while idle and ready: nothing accepted
    rst1 = 1'b1;
    valid1 = 1'b1;
    cmd_data = 32'hFFFF_FFFF;
    cmd_mask = 12'hFFF;
    @(negedge clk);
    check("rstv_ready", 32'(ready1), 32'd0);
    check("rstv_busy", 32'(busy1), 32'd0);
    rst1 = 1'b0;
    valid1 = 1'b0;
    @(negedge clk);
    check("rstv_cmd", 32'(cmd1), 32'd0);
    check("rstv_busy2", 32'(busy1), 32'd0);
    check("rstv_ready2", 32'(ready1), 32'd1);

    // Counting restarts from 0 after reset
    rd = $urandom;
    send(0, rd, 12'h801, 1'b0);
    check_frame(0, rd, 12'h801, 32'h0, 12'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
